// File: rtl/dds_sweep_ctrl_if.sv
// Bundle between the register file (sweep config and strobes) and the DDS
// core tuning inputs.
interface dds_sweep_ctrl_if #(
    parameter int FW = 28,
    parameter int CW = 16
);
    logic          start;
    logic          stop;
    logic [FW-1:0] f_start;
    logic [FW-1:0] f_step;
    logic [CW-1:0] n_steps;
    logic [CW-1:0] dwell;
    logic [1:0]    mode;
    logic [FW-1:0] freq0;
    logic [FW-1:0] freq1;
    logic          fselect;
    logic          busy;
    logic          done;
    logic          hop;
    logic [CW-1:0] step_idx;

    modport master (
        output start, stop, f_start, f_step, n_steps, dwell, mode,
        input  freq0, freq1, fselect, busy, done, hop, step_idx
    );

    modport slave (
        input  start, stop, f_start, f_step, n_steps, dwell, mode,
        output freq0, freq1, fselect, busy, done, hop, step_idx
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Linear sweep/hop sequencer: preloads the inactive DDS tuning register, then
// toggles fselect after each dwell so every hop is phase-continuous.
module dds_sweep_ctrl #(
    parameter int FW = 28,
    parameter int CW = 16
) (
    input logic             clk,
    input logic             rst,
    dds_sweep_ctrl_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {NXT_UP, NXT_DOWN, NXT_START} next_t;

    state_t        state, state_next;
    next_t         nxt;
    logic [FW-1:0] freq0, freq1, cfg_start, cfg_step, cur, freq_next;
    logic [CW-1:0] cfg_n, cfg_d, cnt, idx, idx_next, dwell_c;
    logic [1:0]    cfg_mode;
    logic          fselect, dir, dir_next, preload, done, hop;
    logic          seq_end, hold, accept, do_hop, do_done, last;

    assign dwell_c = (bus.dwell < CW'(2)) ? CW'(2) : bus.dwell;
    assign cur     = fselect ? freq1 : freq0;
    assign last    = (cnt == CW'(1));

    // Where the sequence goes after the current index; dir=1 means down.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        seq_end  = 1'b0;
        hold     = 1'b0;
        idx_next = idx;
        dir_next = dir;
        nxt      = NXT_UP;
        if (cfg_n == '0) begin
            if (cfg_mode[0]) hold = 1'b1;
            else             seq_end = 1'b1;
        end else if (!cfg_mode[1]) begin
            if (idx == cfg_n) begin
                if (cfg_mode[0]) begin
                    idx_next = '0;
                    nxt      = NXT_START;
                end else begin
                    seq_end = 1'b1;
                end
            end else begin
                idx_next = idx + CW'(1);
            end
        end else if (!dir) begin
            if (idx == cfg_n) begin
                dir_next = 1'b1;
                idx_next = idx - CW'(1);
                nxt      = NXT_DOWN;
            end else begin
                idx_next = idx + CW'(1);
            end
        end else begin
            if (idx == '0) begin
                if (cfg_mode[0]) begin
                    dir_next = 1'b0;
                    idx_next = idx + CW'(1);
                end else begin
                    seq_end = 1'b1;
                end
            end else begin
                idx_next = idx - CW'(1);
                nxt      = NXT_DOWN;
            end
        end
    end

    always_comb begin
        case (nxt)
            NXT_DOWN:  freq_next = cur - cfg_step;
            NXT_START: freq_next = cfg_start;
            default:   freq_next = cur + cfg_step;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Stop outranks dwell expiry, so a colliding stop never hops or signals done.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        do_hop     = 1'b0;
        do_done    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_next = IDLE;
                end else if (last) begin
                    if (seq_end) begin
                        do_done    = 1'b1;
                        state_next = IDLE;
                    end else if (!hold) begin
                        do_hop = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            freq0     <= '0;
            freq1     <= '0;
            fselect   <= 1'b0;
            done      <= 1'b0;
            hop       <= 1'b0;
            preload   <= 1'b0;
            idx       <= '0;
            dir       <= 1'b0;
            cnt       <= '0;
            cfg_start <= '0;
            cfg_step  <= '0;
            cfg_n     <= '0;
            cfg_d     <= '0;
            cfg_mode  <= '0;
        end else begin
            done    <= do_done;
            hop     <= do_hop;
            preload <= accept | do_hop;
            if (accept) begin
                cfg_start <= bus.f_start;
                cfg_step  <= bus.f_step;
                cfg_n     <= bus.n_steps;
                cfg_d     <= dwell_c;
                cfg_mode  <= bus.mode;
                idx       <= '0;
                dir       <= 1'b0;
                cnt       <= dwell_c;
                if (fselect) freq1 <= bus.f_start;
                else         freq0 <= bus.f_start;
            end else if (state == RUN) begin
                // Only the unselected register is ever written during a sweep.
                if (preload && !bus.stop) begin
                    if (fselect) freq0 <= freq_next;
                    else         freq1 <= freq_next;
                end
                cnt <= last ? cfg_d : cnt - CW'(1);
                if (do_hop) begin
                    fselect <= ~fselect;
                    idx     <= idx_next;
                    dir     <= dir_next;
                end
            end
        end
    end

    assign bus.freq0    = freq0;
    assign bus.freq1    = freq1;
    assign bus.fselect  = fselect;
    assign bus.busy     = (state == RUN);
    assign bus.done     = done;
    assign bus.hop      = hop;
    assign bus.step_idx = idx;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed and random sweeps compared
// against an index-sequence model of the sweep.
module tb_dds_sweep_ctrl;
    localparam int FW = 28;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    logic exp_fsel = 1'b0;

    always #5 clk = ~clk;

    dds_sweep_ctrl_if #(.FW(FW), .CW(CW)) bus ();
    dds_sweep_ctrl #(.FW(FW), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Number of frequencies a non-repeating sweep visits; 0 means endless.
    function automatic int n_freqs(input int n, input logic [1:0] md);
        if (md[0]) return 0;
        if (n == 0) return 1;
        return md[1] ? 2 * n + 1 : n + 1;
    endfunction

    // Index of the j-th frequency presented since start.
    function automatic int idx_at(input int j, input int n, input logic [1:0] md);
        int p;
        if (n == 0) return 0;
        if (!md[1]) return j % (n + 1);
        p = j % (2 * n);
        return (p <= n) ? p : 2 * n - p;
    endfunction

    function automatic logic [FW-1:0] freq_at(input logic [FW-1:0] fs, input logic [FW-1:0] st,
                                              input int idx);
        return fs + st * FW'(idx);
    endfunction

    // Starts a sweep and checks every cycle. end_k>0 leaves the sweep at cycle
    // end_k, by stop if do_stop, otherwise still running (for a reset).
    task automatic run_sweep(input logic [FW-1:0] fs, input logic [FW-1:0] st, input int n,
                             input int dw, input logic [1:0] md, input int end_k,
                             input bit do_stop);
        int d, nf, j, r, limit, e_idx;
        bit hold, ina_valid;
        logic [FW-1:0] act, ina, e_act, e_ina;
        logic e_fsel, e_hop;
        d     = (dw < 2) ? 2 : dw;
        nf    = n_freqs(n, md);
        hold  = md[0] && (n == 0);
        limit = (nf > 0) ? nf * d + 1 : end_k;
        bus.f_start = fs;
        bus.f_step  = st;
        bus.n_steps = CW'(n);
        bus.dwell   = CW'(dw);
        bus.mode    = md;
        bus.start   = 1'b1;
        bus.stop    = 1'($urandom_range(0, 1));
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            bus.stop = 1'b0;
            j   = (k - 1) / d;
            r   = (k - 1) % d;
            act = bus.fselect ? bus.freq1 : bus.freq0;
            ina = bus.fselect ? bus.freq0 : bus.freq1;
            if (nf > 0 && k == nf * d + 1) begin
                bus.start = 1'b0;
                e_idx  = idx_at(nf - 1, n, md);
                e_act  = freq_at(fs, st, e_idx);
                e_fsel = exp_fsel ^ ((nf - 1) % 2 == 1);
                exp_fsel = e_fsel;
                checks += 5;
                if (bus.busy !== 1'b0) begin failures++; $display("FAIL end_busy k=%0d got=%b exp=0", k, bus.busy); end
                if (bus.done !== 1'b1) begin failures++; $display("FAIL end_done k=%0d got=%b exp=1", k, bus.done); end
                if (bus.hop !== 1'b0) begin failures++; $display("FAIL end_hop k=%0d got=%b exp=0", k, bus.hop); end
                if (act !== e_act) begin failures++; $display("FAIL end_freq k=%0d got=%h exp=%h", k, act, e_act); end
                if (bus.fselect !== e_fsel) begin failures++; $display("FAIL end_fsel k=%0d got=%b exp=%b", k, bus.fselect, e_fsel); end
                return;
            end
            e_idx  = idx_at(j, n, md);
            e_act  = freq_at(fs, st, e_idx);
            e_hop  = (r == 0) && (j > 0) && !hold;
            e_fsel = exp_fsel ^ (!hold && (j % 2 == 1));
            ina_valid = (r >= 1) && !hold && (nf == 0 || j + 1 < nf);
            e_ina  = freq_at(fs, st, idx_at(j + 1, n, md));
            checks += 6;
            if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy k=%0d got=%b exp=1", k, bus.busy); end
            if (bus.done !== 1'b0) begin failures++; $display("FAIL done k=%0d got=%b exp=0", k, bus.done); end
            if (bus.hop !== e_hop) begin failures++; $display("FAIL hop k=%0d got=%b exp=%b", k, bus.hop, e_hop); end
            if (bus.fselect !== e_fsel) begin failures++; $display("FAIL fsel k=%0d got=%b exp=%b", k, bus.fselect, e_fsel); end
            if (act !== e_act) begin failures++; $display("FAIL active k=%0d got=%h exp=%h", k, act, e_act); end
            if (bus.step_idx !== CW'(e_idx)) begin failures++; $display("FAIL step_idx k=%0d got=%0d exp=%0d", k, bus.step_idx, e_idx); end
            if (ina_valid) begin
                checks++;
                if (ina !== e_ina) begin failures++; $display("FAIL preload k=%0d got=%h exp=%h", k, ina, e_ina); end
            end
            // Start and config noise while busy must be ignored.
            bus.start   = 1'($urandom_range(0, 1));
            bus.f_start = FW'($urandom);
            bus.f_step  = FW'($urandom);
            bus.n_steps = CW'($urandom);
            bus.dwell   = CW'($urandom);
            bus.mode    = 2'($urandom);
            if (k == end_k) begin
                exp_fsel = e_fsel;
                if (do_stop) begin
                    bus.stop = 1'b1;
                    @(negedge clk);
                    bus.stop  = 1'b0;
                    bus.start = 1'b0;
                    act = bus.fselect ? bus.freq1 : bus.freq0;
                    ina = bus.fselect ? bus.freq0 : bus.freq1;
                    checks += 5;
                    if (bus.busy !== 1'b0) begin failures++; $display("FAIL stop_busy got=%b exp=0", bus.busy); end
                    if (bus.done !== 1'b0) begin failures++; $display("FAIL stop_done got=%b exp=0", bus.done); end
                    if (bus.hop !== 1'b0) begin failures++; $display("FAIL stop_hop got=%b exp=0", bus.hop); end
                    if (bus.fselect !== e_fsel) begin failures++; $display("FAIL stop_fsel got=%b exp=%b", bus.fselect, e_fsel); end
                    if (act !== e_act) begin failures++; $display("FAIL stop_active got=%h exp=%h", act, e_act); end
                    if (ina_valid) begin
                        checks++;
                        if (ina !== e_ina) begin failures++; $display("FAIL stop_inactive got=%h exp=%h", ina, e_ina); end
                    end
                end
                bus.start = 1'b0;
                return;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.f_start = '0; bus.f_step = '0;
        bus.n_steps = '0; bus.dwell = '0; bus.mode = '0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (bus.freq0 !== '0) begin failures++; $display("FAIL rst_freq0 got=%h exp=0", bus.freq0); end
        if (bus.freq1 !== '0) begin failures++; $display("FAIL rst_freq1 got=%h exp=0", bus.freq1); end
        if (bus.fselect !== 1'b0) begin failures++; $display("FAIL rst_fsel got=%b exp=0", bus.fselect); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus.done); end
        if (bus.hop !== 1'b0) begin failures++; $display("FAIL rst_hop got=%b exp=0", bus.hop); end
        if (bus.step_idx !== '0) begin failures++; $display("FAIL rst_idx got=%0d exp=0", bus.step_idx); end
        rst = 1'b0;
        exp_fsel = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        run_sweep(28'h0000040, 28'h0000003, 3, 4, 2'b01, 11, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks += 4;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", bus.busy); end
        if ({bus.freq0, bus.freq1} !== '0) begin failures++; $display("FAIL mid_rst_freq got=%h/%h exp=0", bus.freq0, bus.freq1); end
        if (bus.fselect !== 1'b0) begin failures++; $display("FAIL mid_rst_fsel got=%b exp=0", bus.fselect); end
        if ({bus.hop, bus.done, bus.step_idx} !== '0) begin failures++; $display("FAIL mid_rst_flags got=%b%b/%0d exp=0", bus.hop, bus.done, bus.step_idx); end
        rst = 1'b0;
        exp_fsel = 1'b0;
        run_sweep(28'h0000200, 28'h0000020, 2, 3, 2'b00, 0, 1'b0);
    endtask

    task automatic test_sawtooth();
        run_sweep(28'h0000100, 28'h0000010, 3, 5, 2'b00, 0, 1'b0);
    endtask

    task automatic test_triangle_repeat();
        run_sweep(28'd10, 28'd1, 2, 2, 2'b11, 26, 1'b1);
    endtask

    task automatic test_negative_wrap();
        run_sweep(28'h0000008, 28'hFFFFFF0, 1, 3, 2'b00, 0, 1'b0);
    endtask

    task automatic test_clamp();
        run_sweep(28'h0001000, 28'h0000100, 2, 0, 2'b00, 0, 1'b0);
        run_sweep(28'h0002000, 28'h0000100, 2, 1, 2'b10, 0, 1'b0);
    endtask

    task automatic test_stop_collision();
        run_sweep(28'h0000500, 28'h0000005, 3, 4, 2'b00, 8, 1'b1);
        run_sweep(28'h0000700, 28'h0000007, 3, 3, 2'b11, 5, 1'b1);
    endtask

    task automatic test_single_freq();
        run_sweep(28'h0000ABC, 28'h0000001, 0, 3, 2'b00, 0, 1'b0);
        run_sweep(28'h0000DEF, 28'h0000001, 0, 2, 2'b11, 15, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_sweep(28'h0000300, 28'h0000001, 1, 2, 2'b10, 0, 1'b0);
        run_sweep(28'h0000400, 28'hFFFFFFF, 2, 2, 2'b00, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [1:0] md;
        for (int i = 0; i < 10; i++) begin
            md = 2'($urandom);
            run_sweep(FW'($urandom), FW'($urandom), $urandom_range(0, 4), $urandom_range(0, 5),
                      md, md[0] ? $urandom_range(1, 40) : 0, md[0]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sawtooth();
        test_triangle_repeat();
        test_negative_wrap();
        test_clamp();
        test_stop_collision();
        test_single_freq();
        test_back_to_back();
        test_random();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
